// File: rtl/lc3b_mem_ctrl.sv
`timescale 1ns/1ps
// LC-3b memory controller: turns the microsequencer's MIO_EN/R handshake into RAM strobes.
// Latency: R is a registered pulse in access cycle LATENCY; mem_rd in cycle LATENCY-1, write strobes with R.
// Backpressure: MIO_EN is held until R; dropping it mid-access aborts. Optional check: LC3B_MEM_UNALIGNED_CHK_EN.
module lc3b_mem_ctrl #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic        DATA_SIZE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_OUT,
  output logic        R,
  output logic [15:0] MEM_DATA,
  output logic        UNALIGNED,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we_lo,
  output logic        mem_we_hi,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // With LATENCY=2 there is no BUSY cycle: the read strobe must fire in the
  // request cycle itself, straight from the live request inputs.
  localparam bit         FAST     = (LATENCY == 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  state_t      state;
  logic [3:0]  cnt;
  logic [14:0] cap_addr;
  logic        cap_a0;
  logic        cap_rw;
  logic        cap_size;
  logic        r_q;
  logic        we_lo_q;
  logic        we_hi_q;
  logic        unal_q;

  logic acc_rw;
  logic acc_size;
  logic acc_a0;
  logic acc_unal;
  logic nx_we_lo;
  logic nx_we_hi;

  // Attributes of the access about to complete: live inputs when finishing straight from IDLE, captured ones otherwise
  always_comb begin
    acc_rw   = (state == IDLE) ? R_W       : cap_rw;
    acc_size = (state == IDLE) ? DATA_SIZE : cap_size;
    acc_a0   = (state == IDLE) ? MAR[0]    : cap_a0;
`ifdef LC3B_MEM_UNALIGNED_CHK_EN
    acc_unal = acc_size & acc_a0;
`else
    acc_unal = 1'b0;
`endif
    // Word writes hit both lanes; byte writes pick the lane from address bit 0
    nx_we_lo = acc_rw & ~acc_unal & (acc_size | ~acc_a0);
    nx_we_hi = acc_rw & ~acc_unal & (acc_size |  acc_a0);
  end

  // Access FSM: capture on request, count down the wait, emit one-cycle completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 15'd0;
      cap_a0    <= 1'b0;
      cap_rw    <= 1'b0;
      cap_size  <= 1'b0;
      mem_wdata <= 16'h0000;
      r_q       <= 1'b0;
      we_lo_q   <= 1'b0;
      we_hi_q   <= 1'b0;
      unal_q    <= 1'b0;
    end else begin
      r_q     <= 1'b0;
      we_lo_q <= 1'b0;
      we_hi_q <= 1'b0;
      unal_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            cap_addr  <= MAR[15:1];
            cap_a0    <= MAR[0];
            cap_rw    <= R_W;
            cap_size  <= DATA_SIZE;
            mem_wdata <= DATA_SIZE ? MDR_OUT : {MDR_OUT[7:0], MDR_OUT[7:0]};
            cnt       <= CNT_INIT;
            if (FAST) begin
              state   <= DONE;
              r_q     <= 1'b1;
              we_lo_q <= nx_we_lo;
              we_hi_q <= nx_we_hi;
              unal_q  <= acc_unal;
            end else begin
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!MIO_EN) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state   <= DONE;
            cnt     <= 4'd0;
            r_q     <= 1'b1;
            we_lo_q <= nx_we_lo;
            we_hi_q <= nx_we_hi;
            unal_q  <= acc_unal;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM address/read strobe; the FAST build presents the live address during the request cycle
  always_comb begin
    mem_addr = (FAST && state == IDLE && rst) ? MAR[15:1] : cap_addr;
    if (FAST)
      mem_rd = rst & MIO_EN & (state == IDLE) & ~R_W;
    else
      mem_rd = rst & MIO_EN & (state == BUSY) & (cnt == 4'd1) & ~cap_rw;
  end

  // Completion outputs; read data is the RAM word returned one cycle after mem_rd
  always_comb begin
    R         = r_q;
    mem_we_lo = we_lo_q;
    mem_we_hi = we_hi_q;
    UNALIGNED = unal_q;
    MEM_DATA  = (r_q && !cap_rw) ? mem_rdata : 16'h0000;
  end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for lc3b_mem_ctrl: one instance at LATENCY=5, one at LATENCY=2.
// Stimulus pushes expected completions/read strobes; negedge monitors pop and compare.
module tb_lc3b_mem_ctrl;

  typedef struct {
    int          cyc;
    logic        rw;
    logic [14:0] addr;
    logic        lo;
    logic        hi;
    logic [15:0] wd;
    logic [15:0] data;
    logic        unal;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [14:0] addr;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mio1, mio2, rw, size;
  logic [15:0] mar, mdr;

  logic        r1, unal1, rd1, lo1, hi1;
  logic [15:0] md1, wd1, rdata1;
  logic [14:0] a1;
  logic        r2, unal2, rd2, lo2, hi2;
  logic [15:0] md2, wd2, rdata2;
  logic [14:0] a2;

  logic [15:0] ram [0:32767];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  exp_t  q1[$], q2[$];
  rexp_t qr1[$], qr2[$];
  exp_t  m1, m2;
  rexp_t mr1, mr2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lc3b_mem_ctrl #(.LATENCY(5)) dut (
    .clk(clk), .rst(rst), .MIO_EN(mio1), .R_W(rw), .DATA_SIZE(size), .MAR(mar), .MDR_OUT(mdr),
    .R(r1), .MEM_DATA(md1), .UNALIGNED(unal1), .mem_addr(a1), .mem_rd(rd1),
    .mem_we_lo(lo1), .mem_we_hi(hi1), .mem_wdata(wd1), .mem_rdata(rdata1)
  );

  lc3b_mem_ctrl #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .MIO_EN(mio2), .R_W(rw), .DATA_SIZE(size), .MAR(mar), .MDR_OUT(mdr),
    .R(r2), .MEM_DATA(md2), .UNALIGNED(unal2), .mem_addr(a2), .mem_rd(rd2),
    .mem_we_lo(lo2), .mem_we_hi(hi2), .mem_wdata(wd2), .mem_rdata(rdata2)
  );

  // Shared RAM model: one-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (lo1) ram[a1][7:0]  <= wd1[7:0];
    if (hi1) ram[a1][15:8] <= wd1[15:8];
    if (lo2) ram[a2][7:0]  <= wd2[7:0];
    if (hi2) ram[a2][15:8] <= wd2[15:8];
    if (rd1) rdata1 <= ram[a1];
    if (rd2) rdata2 <= ram[a2];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor for the LATENCY=5 instance
  always @(negedge clk) begin
    if (r1) begin
      if (q1.size() == 0) chk("r1_unexpected", 32'd1, 32'd0);
      else begin
        m1 = q1.pop_front();
        chk("r1_cycle", cyc, m1.cyc);
        chk("r1_addr", {17'd0, a1}, {17'd0, m1.addr});
        chk("r1_strobes", {30'd0, lo1, hi1}, {30'd0, m1.lo, m1.hi});
        chk("r1_unaligned", {31'd0, unal1}, {31'd0, m1.unal});
        if (m1.rw) chk("r1_wdata", {16'd0, wd1}, {16'd0, m1.wd});
        else       chk("r1_rdata", {16'd0, md1}, {16'd0, m1.data});
      end
    end else begin
      chk("r1_idle_outputs", {13'd0, lo1, hi1, unal1, md1}, 32'd0);
    end
    if (rd1) begin
      if (qr1.size() == 0) chk("rd1_unexpected", 32'd1, 32'd0);
      else begin
        mr1 = qr1.pop_front();
        chk("rd1_cycle", cyc, mr1.cyc);
        chk("rd1_addr", {17'd0, a1}, {17'd0, mr1.addr});
      end
    end
  end

  // Monitor for the LATENCY=2 instance
  always @(negedge clk) begin
    if (r2) begin
      if (q2.size() == 0) chk("r2_unexpected", 32'd1, 32'd0);
      else begin
        m2 = q2.pop_front();
        chk("r2_cycle", cyc, m2.cyc);
        chk("r2_addr", {17'd0, a2}, {17'd0, m2.addr});
        chk("r2_rdata", {16'd0, md2}, {16'd0, m2.data});
      end
    end else begin
      chk("r2_idle_outputs", {13'd0, lo2, hi2, unal2, md2}, 32'd0);
    end
    if (rd2) begin
      if (qr2.size() == 0) chk("rd2_unexpected", 32'd1, 32'd0);
      else begin
        mr2 = qr2.pop_front();
        chk("rd2_cycle", cyc, mr2.cyc);
        chk("rd2_addr", {17'd0, a2}, {17'd0, mr2.addr});
      end
    end
  end

  // One access on the LATENCY=5 instance with hand-computed expectations
  task automatic run_acc(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d,
                         input logic [14:0] e_addr, input logic e_lo, input logic e_hi,
                         input logic [15:0] e_wd, input logic [15:0] e_data, input logic e_un);
    exp_t  e;
    rexp_t re;
    @(posedge clk); #1;
    e.cyc = cyc + 4; e.rw = w; e.addr = e_addr; e.lo = e_lo; e.hi = e_hi;
    e.wd = e_wd; e.data = e_data; e.unal = e_un;
    q1.push_back(e);
    if (!w) begin
      re.cyc = cyc + 3; re.addr = e_addr;
      qr1.push_back(re);
    end
    rw = w; size = s; mar = a; mdr = d; mio1 = 1'b1;
    repeat (5) @(posedge clk);
    #1 mio1 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t  e;
    rexp_t re;
    for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;
    ram[15'h1800] = 16'hBEEF;
    ram[15'h1801] = 16'h1234;
    rst = 1'b0; mio1 = 1'b0; mio2 = 1'b0; rw = 1'b0; size = 1'b0;
    mar = 16'h0000; mdr = 16'h0000;

    // Reset state
    #2;
    chk("reset_r", {31'd0, r1}, 32'd0);
    chk("reset_rd", {31'd0, rd1}, 32'd0);
    chk("reset_addr", {17'd0, a1}, 32'd0);
    chk("reset_wdata", {16'd0, wd1}, 32'd0);
    chk("reset_outs", {13'd0, lo1, hi1, unal1, md1}, 32'd0);
    #20 rst = 1'b1;

    // Word read 0x3000 -> 0xBEEF
    run_acc(1'b0, 1'b1, 16'h3000, 16'h0000, 15'h1800, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0);
    // Byte write 0x3001, MDR 0x12AB -> high lane only, data 0xABAB
    run_acc(1'b1, 1'b0, 16'h3001, 16'h12AB, 15'h1800, 1'b0, 1'b1, 16'hABAB, 16'h0000, 1'b0);

    // Back-to-back reads: MIO_EN high for ten cycles, MAR changed after first capture
    @(posedge clk); #1;
    e.cyc = cyc + 4; e.rw = 1'b0; e.addr = 15'h1800; e.lo = 1'b0; e.hi = 1'b0;
    e.wd = 16'h0; e.data = 16'hABEF; e.unal = 1'b0;
    q1.push_back(e);
    re.cyc = cyc + 3; re.addr = 15'h1800; qr1.push_back(re);
    e.cyc = cyc + 9; e.addr = 15'h1801; e.data = 16'h1234;
    q1.push_back(e);
    re.cyc = cyc + 8; re.addr = 15'h1801; qr1.push_back(re);
    rw = 1'b0; size = 1'b1; mar = 16'h3000; mio1 = 1'b1;
    @(posedge clk); #1 mar = 16'h3002;
    repeat (9) @(posedge clk);
    #1 mio1 = 1'b0;
    repeat (2) @(posedge clk);

    // Abort: MIO_EN drops in cycle 3 of a write
    @(posedge clk); #1;
    rw = 1'b1; size = 1'b1; mar = 16'h3000; mdr = 16'h9999; mio1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 mio1 = 1'b0;
    repeat (6) @(posedge clk);

    // Reset pulse in cycle 4 of a write
    @(posedge clk); #1;
    rw = 1'b1; size = 1'b1; mar = 16'h3000; mdr = 16'h8888; mio1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_r", {31'd0, r1}, 32'd0);
    chk("midrst_addr", {17'd0, a1}, 32'd0);
    chk("midrst_wdata", {16'd0, wd1}, 32'd0);
    mio1 = 1'b0;
    #2 rst = 1'b1;
    repeat (6) @(posedge clk);

    // Word untouched by aborted writes; byte read returns full word with normal timing
    run_acc(1'b0, 1'b0, 16'h3001, 16'h0000, 15'h1800, 1'b0, 1'b0, 16'h0000, 16'hABEF, 1'b0);

    // Word write to odd address 0x4003, then read back word 0x2001
`ifdef LC3B_MEM_UNALIGNED_CHK_EN
    run_acc(1'b1, 1'b1, 16'h4003, 16'h5A5A, 15'h2001, 1'b0, 1'b0, 16'h5A5A, 16'h0000, 1'b1);
    run_acc(1'b0, 1'b1, 16'h4002, 16'h0000, 15'h2001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
`else
    run_acc(1'b1, 1'b1, 16'h4003, 16'h5A5A, 15'h2001, 1'b1, 1'b1, 16'h5A5A, 16'h0000, 1'b0);
    run_acc(1'b0, 1'b1, 16'h4002, 16'h0000, 15'h2001, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0);
`endif

    // LATENCY=2: mem_rd in cycle 1, R with data in cycle 2
    @(posedge clk); #1;
    e.cyc = cyc + 1; e.rw = 1'b0; e.addr = 15'h1801; e.lo = 1'b0; e.hi = 1'b0;
    e.wd = 16'h0; e.data = 16'h1234; e.unal = 1'b0;
    q2.push_back(e);
    re.cyc = cyc; re.addr = 15'h1801; qr2.push_back(re);
    rw = 1'b0; size = 1'b1; mar = 16'h3002; mio2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 mio2 = 1'b0;
    repeat (4) @(posedge clk);

    chk("q1_pending", q1.size(), 32'd0);
    chk("qr1_pending", qr1.size(), 32'd0);
    chk("q2_pending", q2.size(), 32'd0);
    chk("qr2_pending", qr2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
